// File: rtl/ria_pkg.sv
// Shared RIA core types and default dispatch-stage sizing.
package ria_pkg;

    typedef enum logic [1:0] {
        IQ_INT = 2'd0,
        IQ_MEM = 2'd1,
        IQ_FP  = 2'd2
    } iq_type_t;

    localparam int unsigned DISPATCH_WIDTH = 4;
    localparam int unsigned DISPATCH_DEPTH = 16;

endpackage

// File: rtl/dispatch_select.sv
// Prefix-eligibility for the dispatch lanes: in-order, stops at the first lane
// lacking a valid entry, a ROB slot or an issue-queue credit for its type.
module dispatch_select
    import ria_pkg::*;
#(
    parameter int unsigned WIDTH  = DISPATCH_WIDTH,
    parameter int unsigned NUM_IQ = 3,
    parameter int unsigned IQ_W   = (NUM_IQ > 1) ? $clog2(NUM_IQ) : 1,
    parameter int unsigned CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic                    flush_i,
    input  logic [WIDTH-1:0]        lane_avail_i,
    input  logic [WIDTH*IQ_W-1:0]   lane_type_i,
    input  logic [NUM_IQ*CNT_W-1:0] iq_free_i,
    input  logic [CNT_W-1:0]        rob_free_i,
    output logic [WIDTH-1:0]        valid_c_o,
    output logic [CNT_W-1:0]        deq_cnt_c_o
);

    logic [CNT_W-1:0] credit [NUM_IQ];
    logic [CNT_W-1:0] used   [NUM_IQ];
    logic             blocked;
    logic             base_ok;
    logic             cred_ok;

    // Running per-type credit consumption across lanes; an illegal type never matches.
    always_comb begin
        valid_c_o   = '0;
        deq_cnt_c_o = '0;
        blocked     = flush_i;
        base_ok     = 1'b0;
        cred_ok     = 1'b0;
        for (int t = 0; t < int'(NUM_IQ); t++) begin
            credit[t] = iq_free_i[t*CNT_W +: CNT_W];
            used[t]   = '0;
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            base_ok = lane_avail_i[i] && (CNT_W'(i) < rob_free_i);
            cred_ok = 1'b0;
            for (int t = 0; t < int'(NUM_IQ); t++) begin
                if (lane_type_i[i*IQ_W +: IQ_W] == IQ_W'(t) && credit[t] > used[t]) begin
                    cred_ok = 1'b1;
                end
            end
            if (!blocked && base_ok && cred_ok) begin
                valid_c_o[i] = 1'b1;
                deq_cnt_c_o  = deq_cnt_c_o + CNT_W'(1);
                for (int t = 0; t < int'(NUM_IQ); t++) begin
                    if (lane_type_i[i*IQ_W +: IQ_W] == IQ_W'(t)) begin
                        used[t] = used[t] + CNT_W'(1);
                    end
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue between rename and the issue queues.
// Optional DISPATCH_PERF_EN adds saturating stall/empty cycle counters.
module dispatch_queue
    import ria_pkg::*;
#(
    parameter int unsigned WIDTH  = DISPATCH_WIDTH,
    parameter int unsigned DEPTH  = DISPATCH_DEPTH,
    parameter int unsigned NUM_IQ = 3,
    parameter int unsigned UOP_W  = 64,
    parameter int unsigned IQ_W   = (NUM_IQ > 1) ? $clog2(NUM_IQ) : 1,
    parameter int unsigned CNT_W  = $clog2(WIDTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        in_valid,
    input  logic [WIDTH*UOP_W-1:0]  in_uop,
    input  logic [WIDTH*IQ_W-1:0]   in_type,
    output logic                    in_ready,
    input  logic [NUM_IQ*CNT_W-1:0] iq_free,
    input  logic [CNT_W-1:0]        rob_free,
    output logic [WIDTH-1:0]        out_valid,
    output logic [WIDTH*UOP_W-1:0]  out_uop,
    output logic [WIDTH*IQ_W-1:0]   out_type
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]             perf_stall_iq,
    output logic [31:0]             perf_stall_rob,
    output logic [31:0]             perf_empty
`endif
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_Q_W = PTR_W + 1;

    logic [UOP_W-1:0]   mem_q  [DEPTH];
    logic [IQ_W-1:0]    type_q [DEPTH];
    logic [CNT_Q_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic               ready_q, ready_d;
    logic               enq_en;
    logic [CNT_W-1:0]   enq_cnt, deq_cnt;
    logic [WIDTH-1:0]   lane_avail;
    logic [WIDTH*IQ_W-1:0] lane_type;
    logic [PTR_W-1:0]   rd_idx [WIDTH];

    assign in_ready = ready_q;

    // Lane i views entry head+i; payloads are masked to zero when not dispatched.
    always_comb begin
        lane_avail = '0;
        lane_type  = '0;
        out_uop    = '0;
        out_type   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            rd_idx[i]                   = head_q[PTR_W-1:0] + PTR_W'(i);
            lane_avail[i]               = count_q > CNT_Q_W'(i);
            lane_type[i*IQ_W +: IQ_W]   = type_q[rd_idx[i]];
            if (out_valid[i]) begin
                out_uop[i*UOP_W +: UOP_W] = mem_q[rd_idx[i]];
                out_type[i*IQ_W +: IQ_W]  = type_q[rd_idx[i]];
            end
        end
    end

    dispatch_select #(
        .WIDTH  (WIDTH),
        .NUM_IQ (NUM_IQ),
        .IQ_W   (IQ_W),
        .CNT_W  (CNT_W)
    ) u_select (
        .flush_i      (flush),
        .lane_avail_i (lane_avail),
        .lane_type_i  (lane_type),
        .iq_free_i    (iq_free),
        .rob_free_i   (rob_free),
        .valid_c_o    (out_valid),
        .deq_cnt_c_o  (deq_cnt)
    );

    // Pointer/count update; flush wins and drops the same-cycle bundle.
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            enq_cnt = enq_cnt + CNT_W'(in_valid[i]);
        end
        enq_en  = reset && ready_q && in_valid[0] && !flush;
        head_d  = head_q + CNT_Q_W'(deq_cnt);
        tail_d  = tail_q;
        count_d = count_q - CNT_Q_W'(deq_cnt);
        if (enq_en) begin
            tail_d  = tail_q + CNT_Q_W'(enq_cnt);
            count_d = count_d + CNT_Q_W'(enq_cnt);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        ready_d = count_d <= CNT_Q_W'(DEPTH - WIDTH);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq_en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_valid[i]) begin
                    mem_q[tail_q[PTR_W-1:0] + PTR_W'(i)]  <= in_uop[i*UOP_W +: UOP_W];
                    type_q[tail_q[PTR_W-1:0] + PTR_W'(i)] <= in_type[i*IQ_W +: IQ_W];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (enq_en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_valid[i]) begin
                    assert (32'(in_type[i*IQ_W +: IQ_W]) < NUM_IQ)
                        else $error("dispatch_queue: illegal in_type on lane %0d", i);
                end
            end
        end
    end
`endif

`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_iq_q, perf_rob_q, perf_empty_q;
    logic        head_cred_ok;

    // Head entry holds no credit for its type (or carries an illegal type).
    always_comb begin
        head_cred_ok = 1'b0;
        for (int t = 0; t < int'(NUM_IQ); t++) begin
            if (type_q[head_q[PTR_W-1:0]] == IQ_W'(t) && iq_free[t*CNT_W +: CNT_W] != '0) begin
                head_cred_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_iq_q    <= '0;
            perf_rob_q   <= '0;
            perf_empty_q <= '0;
        end else begin
            if (count_q != '0 && !head_cred_ok && perf_iq_q != '1) begin
                perf_iq_q <= perf_iq_q + 32'd1;
            end
            if (count_q != '0 && rob_free == '0 && perf_rob_q != '1) begin
                perf_rob_q <= perf_rob_q + 32'd1;
            end
            if (count_q == '0 && perf_empty_q != '1) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_stall_iq  = perf_iq_q;
    assign perf_stall_rob = perf_rob_q;
    assign perf_empty     = perf_empty_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed vector table plus randomized traffic against a queue-based model.
module tb_dispatch_queue;
    import ria_pkg::*;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned NUM_IQ = 3;
    localparam int unsigned UOP_W  = 64;
    localparam int unsigned IQ_W   = 2;
    localparam int unsigned CNT_W  = 3;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    flush;
    logic [WIDTH-1:0]        in_valid;
    logic [WIDTH*UOP_W-1:0]  in_uop;
    logic [WIDTH*IQ_W-1:0]   in_type;
    logic                    in_ready;
    logic [NUM_IQ*CNT_W-1:0] iq_free;
    logic [CNT_W-1:0]        rob_free;
    logic [WIDTH-1:0]        out_valid;
    logic [WIDTH*UOP_W-1:0]  out_uop;
    logic [WIDTH*IQ_W-1:0]   out_type;

    always #5 clock = ~clock;

    dispatch_queue #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .NUM_IQ (NUM_IQ),
        .UOP_W  (UOP_W),
        .IQ_W   (IQ_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_uop    (in_uop),
        .in_type   (in_type),
        .in_ready  (in_ready),
        .iq_free   (iq_free),
        .rob_free  (rob_free),
        .out_valid (out_valid),
        .out_uop   (out_uop),
        .out_type  (out_type)
    );

    typedef struct packed {
        logic [63:0] uop;
        logic [1:0]  typ;
    } ent_t;

    typedef struct {
        logic       rst_n;
        logic       fl;
        logic [3:0] iv;
        logic [7:0] ty;
        logic [2:0] fi, fm, ff, rob;
        logic [3:0] e_ov;
        logic       e_ir;
    } vec_t;

    ent_t        mq[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] seq = 64'hC0DE_0000_0000_0000;

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] iv,
                                input logic [7:0] ty, input logic [2:0] fi, input logic [2:0] fm,
                                input logic [2:0] ff, input logic [2:0] rob,
                                input logic [3:0] eov, input logic eir);
        vec_t v;
        v.rst_n = r; v.fl = f; v.iv = iv; v.ty = ty;
        v.fi = fi; v.fm = fm; v.ff = ff; v.rob = rob;
        v.e_ov = eov; v.e_ir = eir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive, compare against the model, then advance the model at the edge.
    task automatic do_cycle(input logic rst_n, input logic fl, input logic [3:0] iv,
                            input logic [7:0] ty, input logic [2:0] fi, input logic [2:0] fm,
                            input logic [2:0] ff, input logic [2:0] rob,
                            output logic [3:0] ov_seen, output logic ir_seen);
        int          n;
        int          t;
        int          used[3];
        int          cred[3];
        logic        exp_ir;
        logic [3:0]  exp_ov;
        logic [255:0] exp_uop;
        logic [7:0]  exp_ty;
        ent_t        lane[4];
        @(negedge clock);
        reset    = rst_n;
        flush    = fl;
        in_valid = iv;
        in_type  = ty;
        iq_free  = {ff, fm, fi};
        rob_free = rob;
        for (int i = 0; i < 4; i++) begin
            in_uop[i*64 +: 64] = seq;
            lane[i].uop = seq;
            lane[i].typ = ty[i*2 +: 2];
            seq = seq + 64'd1;
        end
        #1;
        n = 0;
        used = '{0, 0, 0};
        cred = '{int'(fi), int'(fm), int'(ff)};
        exp_ir = (int'(DEPTH) - mq.size()) >= int'(WIDTH);
        if (!fl) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= mq.size() || i >= int'(rob)) break;
                t = int'(mq[i].typ);
                if (t >= 3 || cred[t] <= used[t]) break;
                used[t]++;
                n++;
            end
        end
        exp_ov  = 4'((5'd1 << n) - 5'd1);
        exp_uop = '0;
        exp_ty  = '0;
        for (int i = 0; i < n; i++) begin
            exp_uop[i*64 +: 64] = mq[i].uop;
            exp_ty[i*2 +: 2]    = mq[i].typ;
        end
        chk("model out_valid", 256'(out_valid), 256'(exp_ov));
        chk("model in_ready", 256'(in_ready), 256'(exp_ir));
        chk("model out_uop", out_uop, exp_uop);
        chk("model out_type", 256'(out_type), 256'(exp_ty));
        ov_seen = out_valid;
        ir_seen = in_ready;
        @(posedge clock);
        if (!rst_n || fl) begin
            mq.delete();
        end else begin
            repeat (n) void'(mq.pop_front());
            if (exp_ir && iv[0]) begin
                for (int i = 0; i < 4; i++) if (iv[i]) mq.push_back(lane[i]);
            end
        end
    endtask

    vec_t       tbl[27];
    logic [3:0] ov;
    logic       ir;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = '0; in_uop = '0; in_type = '0;
        iq_free = '0; rob_free = '0;
        @(posedge clock);
        @(posedge clock);

        // reset / basic flow
        tbl[0]  = mk(0, 0, 4'hF, 8'h00, 4, 4, 4, 4, 4'h0, 1);
        tbl[1]  = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'h0, 1);
        tbl[2]  = mk(1, 0, 4'hF, 8'h00, 4, 4, 4, 4, 4'h0, 1);
        tbl[3]  = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'hF, 1);
        tbl[4]  = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'h0, 1);
        // credit limit: INT,INT,MEM,INT
        tbl[5]  = mk(1, 0, 4'hF, 8'h10, 1, 4, 4, 4, 4'h0, 1);
        tbl[6]  = mk(1, 0, 4'h0, 8'h00, 1, 4, 4, 4, 4'h1, 1);
        tbl[7]  = mk(1, 0, 4'h0, 8'h00, 2, 4, 4, 4, 4'h7, 1);
        // ROB limit, full, wrap
        tbl[8]  = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 0, 4'h0, 1);
        tbl[9]  = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 0, 4'h0, 1);
        tbl[10] = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 0, 4'h0, 1);
        tbl[11] = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 0, 4'h0, 1);
        tbl[12] = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 0, 4'h0, 0);
        tbl[13] = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 2, 4'h3, 0);
        tbl[14] = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 2, 4'h3, 0);
        tbl[15] = mk(1, 0, 4'hF, 8'h49, 4, 4, 4, 2, 4'h3, 1);
        tbl[16] = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 2, 4'h3, 0);
        tbl[17] = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 2, 4'h3, 1);
        // flush at count 10
        tbl[18] = mk(1, 1, 4'h3, 8'h00, 4, 4, 4, 4, 4'h0, 1);
        tbl[19] = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'h0, 1);
        // simultaneous enqueue/dequeue at count 8
        tbl[20] = mk(1, 0, 4'hF, 8'h00, 4, 4, 4, 0, 4'h0, 1);
        tbl[21] = mk(1, 0, 4'hF, 8'h00, 4, 4, 4, 0, 4'h0, 1);
        tbl[22] = mk(1, 0, 4'hF, 8'h00, 4, 4, 4, 3, 4'h7, 1);
        tbl[23] = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'hF, 1);
        tbl[24] = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'hF, 1);
        tbl[25] = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'h1, 1);
        tbl[26] = mk(1, 0, 4'h0, 8'h00, 4, 4, 4, 4, 4'h0, 1);

        for (int k = 0; k < 27; k++) begin
            do_cycle(tbl[k].rst_n, tbl[k].fl, tbl[k].iv, tbl[k].ty, tbl[k].fi, tbl[k].fm,
                     tbl[k].ff, tbl[k].rob, ov, ir);
            chk($sformatf("vec%0d out_valid", k), 256'(ov), 256'(tbl[k].e_ov));
            chk($sformatf("vec%0d in_ready", k), 256'(ir), 256'(tbl[k].e_ir));
        end

        for (int c = 0; c < 1500; c++) begin
            logic [3:0] riv;
            logic [7:0] rty;
            int         len;
            len = $urandom_range(0, 4);
            riv = 4'((5'd1 << len) - 5'd1);
            for (int i = 0; i < 4; i++) rty[i*2 +: 2] = 2'($urandom_range(0, 2));
            do_cycle(1'b1, ($urandom_range(0, 31) == 0), riv, rty,
                     3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                     3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), ov, ir);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
